// File: rtl/hazard_ctrl.sv
// Pipeline interlock scheduler: load-use, multiply occupancy, branch squash and memory-wait freeze.
// Optional perf counters o_stall_cnt / o_flush_cnt are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MUL_CNT_W    = 4,
  parameter int unsigned PERF_W       = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_id_valid,
  input  logic [3:0]           i_id_rm_code,
  input  logic [3:0]           i_id_rn_code,
  input  logic [3:0]           i_id_rs_code,
  input  logic [2:0]           i_id_use,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_is_load,
  input  logic                 i_ex_rd_en,
  input  logic [3:0]           i_ex_rd_code,
  input  logic                 i_mul_start,
  input  logic [MUL_CNT_W-1:0] i_mul_cycles,
  input  logic                 i_branch_taken,
  input  logic                 i_mem_wait,
  output logic                 o_stall_if,
  output logic                 o_stall_id,
  output logic                 o_stall_ex,
  output logic                 o_bubble_ex,
  output logic                 o_flush_id,
  output logic                 o_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]    o_stall_cnt,
  output logic [PERF_W-1:0]    o_flush_cnt
`endif
);

  localparam int unsigned CNT_W = (MUL_CNT_W > 3) ? MUL_CNT_W : 3;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam bit FLUSH_MULTI = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic stall_if_c, stall_id_c, stall_ex_c, bubble_c, flush_c;
  logic rm_hit, rn_hit, rs_hit, load_use, mul_long;

  // A load result is only usable from WB, so a used operand matching it needs one bubble.
  assign rm_hit   = i_id_use[0] && (i_id_rm_code == i_ex_rd_code);
  assign rn_hit   = i_id_use[1] && (i_id_rn_code == i_ex_rd_code);
  assign rs_hit   = i_id_use[2] && (i_id_rs_code == i_ex_rd_code);
  assign load_use = i_id_valid && i_ex_valid && i_ex_is_load && i_ex_rd_en &&
                    (rm_hit || rn_hit || rs_hit);
  assign mul_long = i_mul_start && (i_mul_cycles > MUL_CNT_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and same-cycle pipeline controls, in priority order.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_if_c = 1'b0;
    stall_id_c = 1'b0;
    stall_ex_c = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    if (i_mem_wait) begin
      stall_if_c = 1'b1;
      stall_id_c = 1'b1;
      stall_ex_c = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_branch_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            if (FLUSH_MULTI) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_LOAD;
            end
          end else if (mul_long) begin
            state_d = MUL;
            cnt_d   = CNT_W'(i_mul_cycles) - CNT_W'(1);
          end else if (load_use) begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            bubble_c   = 1'b1;
          end
        end
        MUL: begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          stall_ex_c = 1'b1;
          cnt_d      = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
        FLUSH: begin
          flush_c = 1'b1;
          if (i_branch_taken) begin
            bubble_c = 1'b1;
            cnt_d    = FLUSH_LOAD;
          end else begin
            cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
            if (cnt_q <= CNT_W'(1)) begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Controls are forced low while reset is asserted, whatever the inputs do.
  assign o_stall_if  = i_rst_n && stall_if_c;
  assign o_stall_id  = i_rst_n && stall_id_c;
  assign o_stall_ex  = i_rst_n && stall_ex_c;
  assign o_bubble_ex = i_rst_n && bubble_c;
  assign o_flush_id  = i_rst_n && flush_c;
  assign o_busy      = (state_q != IDLE);

`ifdef HAZARD_PERF_EN
  // Saturating event counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_stall_if && (o_stall_cnt != {PERF_W{1'b1}})) begin
        o_stall_cnt <= o_stall_cnt + PERF_W'(1);
      end
      if (o_flush_id && (o_flush_cnt != {PERF_W{1'b1}})) begin
        o_flush_cnt <= o_flush_cnt + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, corner sequences, random vs. model.
module tb_hazard_ctrl;

  localparam int unsigned FC = 2;

  logic       i_clk, i_rst_n;
  logic       i_id_valid, i_ex_valid, i_ex_is_load, i_ex_rd_en;
  logic [3:0] i_id_rm_code, i_id_rn_code, i_id_rs_code, i_ex_rd_code;
  logic [2:0] i_id_use;
  logic       i_mul_start, i_branch_taken, i_mem_wait;
  logic [3:0] i_mul_cycles;
  logic       o_stall_if, o_stall_id, o_stall_ex, o_bubble_ex, o_flush_id, o_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] o_stall_cnt, o_flush_cnt;
`endif

  hazard_ctrl #(.FLUSH_CYCLES(FC), .MUL_CNT_W(4), .PERF_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_valid(i_id_valid), .i_id_rm_code(i_id_rm_code), .i_id_rn_code(i_id_rn_code),
    .i_id_rs_code(i_id_rs_code), .i_id_use(i_id_use),
    .i_ex_valid(i_ex_valid), .i_ex_is_load(i_ex_is_load), .i_ex_rd_en(i_ex_rd_en),
    .i_ex_rd_code(i_ex_rd_code), .i_mul_start(i_mul_start), .i_mul_cycles(i_mul_cycles),
    .i_branch_taken(i_branch_taken), .i_mem_wait(i_mem_wait),
    .o_stall_if(o_stall_if), .o_stall_id(o_stall_id), .o_stall_ex(o_stall_ex),
    .o_bubble_ex(o_bubble_ex), .o_flush_id(o_flush_id), .o_busy(o_busy)
`ifdef HAZARD_PERF_EN
    , .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       idv;
    logic [3:0] rm, rn, rs;
    logic [2:0] uses;
    logic       exv, ld, rden;
    logic [3:0] rd;
    logic       ms;
    logic [3:0] mc;
    logic       br, mw;
    logic [5:0] exp;  // {stall_if, stall_id, stall_ex, bubble_ex, flush_id, busy}
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining stalled multiply cycles and remaining post-branch flush cycles.
  int      mul_left   = 0;
  int      flush_left = 0;
  longint  perf_stall = 0;
  longint  perf_flush = 0;

  function automatic vec_t mk(input logic idv, input logic [3:0] rm, rn, rs, input logic [2:0] uses,
                              input logic exv, ld, rden, input logic [3:0] rd, input logic ms,
                              input logic [3:0] mc, input logic br, mw, input logic [5:0] exp);
    vec_t v;
    v.idv = idv; v.rm = rm; v.rn = rn; v.rs = rs; v.uses = uses;
    v.exv = exv; v.ld = ld; v.rden = rden; v.rd = rd;
    v.ms = ms; v.mc = mc; v.br = br; v.mw = mw; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_id_valid = v.idv; i_id_rm_code = v.rm; i_id_rn_code = v.rn; i_id_rs_code = v.rs;
    i_id_use = v.uses; i_ex_valid = v.exv; i_ex_is_load = v.ld; i_ex_rd_en = v.rden;
    i_ex_rd_code = v.rd; i_mul_start = v.ms; i_mul_cycles = v.mc;
    i_branch_taken = v.br; i_mem_wait = v.mw;
  endtask

  function automatic logic [5:0] outs();
    return {o_stall_if, o_stall_id, o_stall_ex, o_bubble_ex, o_flush_id, o_busy};
  endfunction

  task automatic model_reset();
    mul_left = 0; flush_left = 0; perf_stall = 0; perf_flush = 0;
  endtask

  task automatic model_step(input vec_t v, output logic [5:0] e);
    logic sif, sid, sex, bub, fl, busy, hit;
    sif = 0; sid = 0; sex = 0; bub = 0; fl = 0;
    busy = (mul_left > 0) || (flush_left > 0);
    hit = v.idv && v.exv && v.ld && v.rden &&
          ((v.uses[0] && v.rm == v.rd) || (v.uses[1] && v.rn == v.rd) || (v.uses[2] && v.rs == v.rd));
    if (v.mw) begin
      sif = 1; sid = 1; sex = 1;
    end else if (mul_left > 0) begin
      sif = 1; sid = 1; sex = 1;
      mul_left--;
    end else if (flush_left > 0) begin
      fl = 1;
      if (v.br) begin bub = 1; flush_left = FC - 1; end
      else flush_left--;
    end else if (v.br) begin
      fl = 1; bub = 1; flush_left = FC - 1;
    end else if (v.ms && v.mc >= 2) begin
      mul_left = int'(v.mc) - 1;
    end else if (hit) begin
      sif = 1; sid = 1; bub = 1;
    end
    if (sif) perf_stall++;
    if (fl) perf_flush++;
    e = {sif, sid, sex, bub, fl, busy};
  endtask

  task automatic step(input vec_t v, output logic [5:0] got, output logic [5:0] exp);
    @(negedge i_clk);
    drive(v);
    #1;
    got = outs();
    model_step(v, exp);
  endtask

  vec_t tbl[32];
  vec_t z, v;
  logic [5:0] got, exp;
  int sex_cnt, busy_cnt;

  initial begin
    z = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
    tbl[0]  = z;
    tbl[1]  = mk(1, 2, 3, 0, 3'b011, 1, 1, 1, 3, 0, 0, 0, 0, 6'b110100); // LDR r3 / ADD r1,r3,r2
    tbl[2]  = mk(1, 2, 3, 0, 3'b011, 1, 0, 1, 1, 0, 0, 0, 0, 6'b000000);
    tbl[3]  = mk(1, 2, 3, 0, 3'b001, 1, 1, 1, 3, 0, 0, 0, 0, 6'b000000); // rn match but unused
    tbl[4]  = mk(1, 2, 5, 3, 3'b100, 1, 1, 1, 3, 0, 0, 0, 0, 6'b110100); // rs match
    tbl[5]  = mk(1, 2, 3, 0, 3'b011, 1, 1, 0, 3, 0, 0, 0, 0, 6'b000000); // no Rd write
    tbl[6]  = mk(0, 2, 3, 0, 3'b011, 1, 1, 1, 3, 0, 0, 0, 0, 6'b000000); // ID invalid
    tbl[7]  = mk(1, 3, 5, 0, 3'b001, 1, 1, 1, 3, 0, 0, 0, 0, 6'b110100); // rm match
    tbl[8]  = mk(1, 2, 3, 0, 3'b011, 1, 1, 1, 3, 0, 0, 1, 0, 6'b000110); // branch beats load-use
    tbl[9]  = mk(1, 2, 3, 0, 3'b011, 1, 1, 1, 3, 0, 0, 0, 0, 6'b000011);
    tbl[10] = z;
    tbl[11] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 4, 0, 0, 6'b000000); // mul N=4
    tbl[12] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111001);
    tbl[13] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 6'b111001); // branch ignored in MUL
    tbl[14] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111001);
    tbl[15] = z;
    tbl[16] = mk(1, 2, 3, 0, 3'b011, 1, 1, 1, 3, 1, 1, 0, 0, 6'b110100); // N=1 falls to load-use
    tbl[17] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 6'b111000); // wait beats branch
    tbl[18] = z;
    tbl[19] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 2, 0, 0, 6'b000000); // mul N=2
    tbl[20] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111001);
    tbl[21] = z;
    tbl[22] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000110);
    tbl[23] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000111); // reload in FLUSH
    tbl[24] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000011);
    tbl[25] = z;
    tbl[26] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000110);
    tbl[27] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 6'b111001); // wait freezes FLUSH
    tbl[28] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000011);
    tbl[29] = z;
    tbl[30] = mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 4, 0, 1, 6'b111000); // wait blocks mul start
    tbl[31] = z;

    // Reset: outputs low even with active inputs.
    i_rst_n = 1'b0;
    drive(z);
    #1;
    check("reset_idle", outs(), 6'b000000);
    v = z; v.mw = 1; v.br = 1;
    drive(v);
    #1;
    check("reset_active_inputs", outs(), 6'b000000);
    @(negedge i_clk);
    drive(z);
    i_rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 32; i++) begin
      step(tbl[i], got, exp);
      check($sformatf("vec%0d", i), got, tbl[i].exp);
    end

    // Memory wait held two cycles in the middle of a 4-cycle multiply.
    v = z; v.ms = 1; v.mc = 4;
    step(v, got, exp);
    sex_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      v = z; v.mw = (i == 1 || i == 2);
      step(v, got, exp);
      sex_cnt  += int'(got[3]);
      busy_cnt += int'(got[0]);
    end
    check_int("mul_wait_stall_ex", sex_cnt, 5);
    check_int("mul_wait_busy", busy_cnt, 5);

    // Asynchronous reset while in FLUSH.
    v = z; v.br = 1;
    step(v, got, exp);
    @(negedge i_clk);
    v = z; v.br = 1; v.mw = 1;
    drive(v);
    #1;
    check("pre_reset_flush", outs(), 6'b111001);
    i_rst_n = 1'b0;
    #1;
    check("reset_in_flush", outs(), 6'b000000);
`ifdef HAZARD_PERF_EN
    check_int("reset_stall_cnt", o_stall_cnt, 0);
    check_int("reset_flush_cnt", o_flush_cnt, 0);
`endif
    model_reset();
    @(negedge i_clk);
    drive(z);
    i_rst_n = 1'b1;
    step(z, got, exp);
    check("post_reset", got, 6'b000000);

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      v.idv  = ($urandom_range(3) != 0);
      v.rm   = 4'($urandom_range(3));
      v.rn   = 4'($urandom_range(3));
      v.rs   = 4'($urandom_range(3));
      v.uses = 3'($urandom_range(7));
      v.exv  = ($urandom_range(3) != 0);
      v.ld   = 1'($urandom_range(1));
      v.rden = ($urandom_range(3) != 0);
      v.rd   = 4'($urandom_range(3));
      v.ms   = ($urandom_range(5) == 0);
      v.mc   = 4'($urandom_range(15));
      v.br   = ($urandom_range(9) == 0);
      v.mw   = ($urandom_range(7) == 0);
      step(v, got, exp);
      check($sformatf("rand%0d", i), got, exp);
    end

`ifdef HAZARD_PERF_EN
    @(negedge i_clk);
    drive(z);
    @(negedge i_clk);
    check_int("perf_stall_cnt", o_stall_cnt, perf_stall);
    check_int("perf_flush_cnt", o_flush_cnt, perf_flush);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
